// File: rtl/pwm_duty_ctrl.sv
// Button-driven PWM duty controller: saturating setpoint, period-boundary duty updates, OFF/RAMP/RUN soft start.
// Optional soft-start RAMP state is built only when PWM_DUTY_CTRL_SOFTSTART_EN is defined.
`timescale 1ns/1ps
module pwm_duty_ctrl #(
  parameter int PWM_WIDTH = 8,
  parameter int DUTY_STEP = 16,
  parameter int DUTY_INIT = 128,
  parameter int RAMP_STEP = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 ce_i,
  input  logic                 ena_i,
  input  logic                 up_ceo_i,
  input  logic                 dn_ceo_i,
  output logic                 pwm_out_o,
  output logic [PWM_WIDTH-1:0] duty_o,
  output logic [PWM_WIDTH-1:0] duty_act_o,
  output logic                 period_ceo_o,
  output logic                 ramping_o
);

  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PWM_WIDTH:0]   MAX_EXT = {1'b0, CNT_MAX};
  localparam logic [PWM_WIDTH:0]   DSTEP   = (PWM_WIDTH+1)'(DUTY_STEP);
  localparam logic [PWM_WIDTH-1:0] INIT_V  = PWM_WIDTH'(DUTY_INIT);

`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
  localparam logic [PWM_WIDTH:0] RSTEP = (PWM_WIDTH+1)'(RAMP_STEP);
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RAMP = 2'd1, ST_RUN = 2'd2} state_t;
`else
  typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;
`endif

  state_t                 state_q;
  logic [PWM_WIDTH-1:0]   cnt_q;
  logic [PWM_WIDTH-1:0]   duty_q;
  logic [PWM_WIDTH-1:0]   duty_d;
  logic [PWM_WIDTH-1:0]   duty_act_q;
  logic                   pwm_q;
  logic                   period_q;
  logic                   wrap;
  logic [PWM_WIDTH:0]     up_sum;
  logic [PWM_WIDTH:0]     dn_diff;

  // Setpoint math is one bit wider so both directions saturate instead of wrapping.
  always_comb begin
    up_sum  = {1'b0, duty_q} + DSTEP;
    dn_diff = {1'b0, duty_q} - DSTEP;
    duty_d  = duty_q;
    if (up_ceo_i && !dn_ceo_i) begin
      duty_d = (up_sum > MAX_EXT) ? CNT_MAX : up_sum[PWM_WIDTH-1:0];
    end else if (dn_ceo_i && !up_ceo_i) begin
      duty_d = ({1'b0, duty_q} < DSTEP) ? '0 : dn_diff[PWM_WIDTH-1:0];
    end
  end

  assign wrap = ce_i && (cnt_q == CNT_MAX) && (state_q != ST_OFF);

`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
  logic                 ramping_q;
  logic [PWM_WIDTH:0]   ramp_sum;
  assign ramp_sum  = {1'b0, duty_act_q} + RSTEP;
  assign ramping_o = ramping_q;
`else
  assign ramping_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      duty_q     <= INIT_V;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
      period_q   <= 1'b0;
`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
      ramping_q  <= 1'b0;
`endif
    end else begin
      duty_q   <= duty_d;
      period_q <= wrap;
      pwm_q    <= (state_q != ST_OFF) && (cnt_q < duty_act_q);
      // Disable wins over everything else, including a coincident wrap.
      if (!ena_i) begin
        state_q    <= ST_OFF;
        cnt_q      <= '0;
        duty_act_q <= '0;
        pwm_q      <= 1'b0;
`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
        ramping_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_OFF: begin
`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
            state_q    <= ST_RAMP;
            ramping_q  <= 1'b1;
            duty_act_q <= '0;
`else
            state_q    <= ST_RUN;
            duty_act_q <= duty_q;
`endif
          end
`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
          ST_RAMP: begin
            if (ce_i) cnt_q <= cnt_q + PWM_WIDTH'(1);
            // A lowered setpoint mid-ramp also lands here since ramp_sum then exceeds it.
            if (wrap) begin
              if (ramp_sum >= {1'b0, duty_q}) begin
                duty_act_q <= duty_q;
                state_q    <= ST_RUN;
                ramping_q  <= 1'b0;
              end else begin
                duty_act_q <= ramp_sum[PWM_WIDTH-1:0];
              end
            end
          end
`endif
          ST_RUN: begin
            if (ce_i) cnt_q <= cnt_q + PWM_WIDTH'(1);
            if (wrap) duty_act_q <= duty_q;
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign pwm_out_o    = pwm_q;
  assign duty_o       = duty_q;
  assign duty_act_o   = duty_act_q;
  assign period_ceo_o = period_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Randomized + directed bench for pwm_duty_ctrl against an arithmetic reference model.
// Honours PWM_DUTY_CTRL_SOFTSTART_EN the same way the design does.
`timescale 1ns/1ps
module tb_pwm_duty_ctrl;
`ifdef PWM_DUTY_CTRL_SOFTSTART_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, ena = 1'b0, up = 1'b0, dn = 1'b0;
  logic pwm, per, ramping;
  logic [7:0] duty, duty_act;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pwm_duty_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .ena_i(ena), .up_ceo_i(up), .dn_ceo_i(dn),
    .pwm_out_o(pwm), .duty_o(duty), .duty_act_o(duty_act), .period_ceo_o(per), .ramping_o(ramping)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=off, 1=ramping, 2=running; plain integer arithmetic.
  int m_mode, m_cnt, m_sp, m_act;
  bit m_pwm, m_per, m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int nsp, nact, ncnt, nmode;
    bit wrap;
    if (!rst_n) begin
      m_mode <= 0; m_cnt <= 0; m_sp <= 128; m_act <= 0;
      m_pwm <= 1'b0; m_per <= 1'b0; m_valid <= 1'b1;
    end else begin
      nsp = m_sp;
      if (up && !dn)      nsp = (m_sp + 16 > 255) ? 255 : m_sp + 16;
      else if (dn && !up) nsp = (m_sp < 16) ? 0 : m_sp - 16;
      wrap  = ce && (m_cnt == 255) && (m_mode != 0);
      nmode = m_mode; nact = m_act; ncnt = m_cnt;
      if (!ena) begin
        nmode = 0; ncnt = 0; nact = 0;
      end else if (m_mode == 0) begin
        nmode = SS ? 1 : 2;
        nact  = SS ? 0 : m_sp;
      end else begin
        if (ce) ncnt = (m_cnt + 1) % 256;
        if (wrap) begin
          if (m_mode == 1) begin
            nact = (m_act + 32 < m_sp) ? m_act + 32 : m_sp;
            if (nact == m_sp) nmode = 2;
          end else begin
            nact = m_sp;
          end
        end
      end
      m_pwm  <= ena && (m_mode != 0) && (m_cnt < m_act);
      m_per  <= wrap;
      m_sp   <= nsp;
      m_act  <= nact;
      m_cnt  <= ncnt;
      m_mode <= nmode;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_pwm", {31'd0, pwm}, {31'd0, m_pwm});
      check("m_duty", {24'd0, duty}, m_sp);
      check("m_duty_act", {24'd0, duty_act}, m_act);
      check("m_period", {31'd0, per}, {31'd0, m_per});
      check("m_ramping", {31'd0, ramping}, (m_mode == 1) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic u, input logic d);
    up = u; dn = d;
    tick();
    up = 1'b0; dn = 1'b0;
  endtask

  task automatic wait_per();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!per && n < 2000);
    check("period_seen", {31'd0, per}, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pwm"}, {31'd0, pwm}, 0);
    check({tag, "_duty"}, {24'd0, duty}, 128);
    check({tag, "_act"}, {24'd0, duty_act}, 0);
    check({tag, "_per"}, {31'd0, per}, 0);
    check({tag, "_ramping"}, {31'd0, ramping}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, p1, p2, wide;
    bit prev;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst_n = 1'b1; ena = 1'b1; ce = 1'b1;
    $display("start-up ramp, soft start=%0d", SS);

    for (int n = 1; n <= 4; n++) begin
      wait_per();
      check("ramp_act", {24'd0, duty_act}, SS ? 32 * n : 128);
      check("ramp_flag", {31'd0, ramping}, (SS && n < 4) ? 1 : 0);
    end

    hi = 0;
    repeat (256) begin
      tick();
      hi += int'(pwm);
    end
    check("pwm_high_ticks", hi, 128);

    repeat (100) tick();
    press(1'b1, 1'b0);
    check("mid_up_duty", {24'd0, duty}, 144);
    check("mid_up_act_held", {24'd0, duty_act}, 128);
    wait_per();
    check("mid_up_act_applied", {24'd0, duty_act}, 144);
    $display("mid-period press applied at boundary, duty_act=%0d", duty_act);

    repeat (6) press(1'b1, 1'b0);
    check("up_to_240", {24'd0, duty}, 240);
    repeat (3) begin
      press(1'b1, 1'b0);
      check("sat_high", {24'd0, duty}, 255);
    end
    press(1'b1, 1'b1);
    check("both_at_255", {24'd0, duty}, 255);
    repeat (16) press(1'b0, 1'b1);
    check("down_to_0", {24'd0, duty}, 0);
    press(1'b1, 1'b0);
    check("up_to_16", {24'd0, duty}, 16);
    repeat (2) begin
      press(1'b0, 1'b1);
      check("sat_low", {24'd0, duty}, 0);
    end
    press(1'b1, 1'b1);
    check("both_at_0", {24'd0, duty}, 0);
    repeat (8) press(1'b1, 1'b0);
    check("back_to_128", {24'd0, duty}, 128);
    wait_per();
    check("act_128_again", {24'd0, duty_act}, 128);
    $display("saturation sequence done, duty=%0d", duty);

    repeat (50) tick();
    ena = 1'b0;
    tick();
    check("dis_pwm", {31'd0, pwm}, 0);
    check("dis_act", {24'd0, duty_act}, 0);
    check("dis_per", {31'd0, per}, 0);
    check("dis_ramping", {31'd0, ramping}, 0);
    ena = 1'b1;
    tick();
    check("reen_act", {24'd0, duty_act}, SS ? 0 : 128);
    check("reen_ramping", {31'd0, ramping}, SS ? 1 : 0);
    $display("enable dropped and restored, duty_act=%0d ramping=%0d", duty_act, ramping);

    if (SS) begin
      repeat (3) wait_per();
      check("ramp_96", {24'd0, duty_act}, 96);
      repeat (4) press(1'b0, 1'b1);
      check("lowered_64", {24'd0, duty}, 64);
      wait_per();
      check("ramp_cut_act", {24'd0, duty_act}, 64);
      check("ramp_cut_flag", {31'd0, ramping}, 0);
      $display("setpoint lowered mid-ramp, duty_act=%0d", duty_act);
    end

    p1 = -1; p2 = -1; wide = 0; prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ce = (i % 4 == 0);
      tick();
      if (per && prev) wide++;
      if (per && !prev) begin
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
      prev = per;
    end
    check("ce_quarter_period", p2 - p1, 1024);
    check("period_pulse_width", wide, 0);
    $display("quarter-rate CE: pulses at %0d and %0d", p1, p2);

    ce = 1'b1;
    repeat (37) tick();
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    tick();
    rst_n = 1'b1;
    $display("asynchronous reset mid-period checked");

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(599) == 0) ena = ~ena;
      ce = ((i / 2000) % 2 == 0) ? 1'b1 : 1'($urandom_range(1));
      up = ($urandom_range(39) == 0);
      dn = ($urandom_range(39) == 0);
      tick();
      if ($urandom_range(3999) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rand_rst_duty", {24'd0, duty}, 128);
        tick();
        rst_n = 1'b1;
        $display("random reset at iteration %0d", i);
      end
    end
    up = 1'b0; dn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
